alu_bist: RTL and testbench
===========================

// Module: alu_bist
// PURPOSE
//  Synthesizable self-test sequencer for the single-cycle CPU ALU.
//  Applies a fixed vector table to the ALU operand/function inputs, samples result S, and compares it to the stored expected value.
//  Counts mismatches and reports pass/fail. Sits beside the ALU, muxed onto its inputs in test mode; it is the on-chip checker consuming S.
// PARAMETERS
//  NUM_VEC  16  vectors executed per run, 1..16 (table depth is 16)
//  SETTLE   1   cycles between driving inputs and sampling alu_s, >=1
//  ERR_W    5   width of err_count, saturating
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   1-cycle pulse; begins a run when idle or done
//  alu_a          out  32  ALU operand A
//  alu_b          out  32  ALU operand B
//  alu_fun        out  6   ALU function code (ALUfun)
//  alu_sign       out  1   signed-compare select (Sign)
//  alu_s          in   32  ALU result S
//  busy           out  1   run in progress
//  done           out  1   run complete; held until next start or reset
//  pass           out  1   valid when done: 1 iff err_count==0
//  err_count      out  ERR_W  mismatches this run, saturates at all-ones
//  first_fail     out  4   index of first mismatching vector, 0 if none
// BEHAVIOUR
//  Reset (async, active-high): state IDLE; all outputs 0; vector index 0.
//  FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
//   IDLE  : start -> DRIVE; clear err_count and first_fail; idx=0.
//   DRIVE : register table[idx] onto alu_a/b/fun/sign; wcnt=SETTLE-1 -> WAIT.
//   WAIT  : wcnt==0 -> CHECK, else decrement.
//   CHECK : compare alu_s vs expected[idx]. On mismatch, err_count+1 (saturating); if first mismatch, first_fail=idx.
//           idx==NUM_VEC-1 -> DONE, else idx+1 -> DRIVE.
//   DONE  : done=1, pass=(err_count==0); start -> DRIVE with counters cleared.
//  busy=1 in DRIVE/WAIT/CHECK. start while busy is ignored.
//  alu_* hold the last driven vector in CHECK/DONE; 0 in IDLE.
//  Per-vector latency = SETTLE+2 cycles. Run = NUM_VEC*(SETTLE+2)+1 cycles, start to done.
//  Reset mid-run aborts immediately to the reset state; no partial results are retained.
//  Function codes: ADD 000000  SUB 000001  AND 011000  OR 011110  XOR 010110  NOR 010001  A 011010
//   SLL 100000  SRL 100001  SRA 100011 (shift B by A[4:0])
//   EQ 110011  NEQ 110001  LT 110101  LEZ 111101  GEZ 111001  GTZ 111111 (compares: S={31'b0,flag}; LEZ/GEZ/GTZ test A)
//  Table covers all 16 codes, one vector each, in the order listed above.
//  Row 0 is ADD, A=DAFB0219, B=22B042D1; row 1 is SUB, same operands.
//  Row 9 (SRA) uses B[31]=1. Row 12 (LT) is run with Sign=1.
// STRUCTURE
//  Package alu_pkg: ALUfun code constants (above), state enum encoding, table depth 16.
//  Sub-module alu_bist_rom: combinational, idx[3:0] -> {a, b, fun, sign, expected}.
//  alu_bist contains the FSM, counters and compare logic.
// TESTING
//  1 reset, then start with a correct ALU attached:
//    busy for 16*3 cycles, then done=1, pass=1, err_count=0, first_fail=0.
//  2 ADD row (A=DAFB0219, B=22B042D1): alu_s checked equal to FDAB44EA.
//    SUB row: B84ABF48. AND row: 02B00211. OR row: FAFB42D9.
//  3 bench forces alu_s^=1 on vectors 1 and 5:
//    err_count=2, first_fail=1, pass=0.
//  4 bench forces alu_s=0 on every vector:
//    err_count=the count of rows with nonzero expected, saturating, pass=0.
//  5 assert reset during vector 7 CHECK:
//    all outputs 0 next edge, state IDLE; a new start reruns cleanly to pass=1.
//  6 start pulses while busy are ignored; run length unchanged.
//    start in DONE restarts with counters cleared.
//    SETTLE=3 build: per-vector spacing is 5 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU function codes and shared types for the ALU self-test block.
// Imported by the BIST sequencer and its vector ROM.
package alu_pkg;

  localparam int TBL_DEPTH = 16;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b011000;
  localparam logic [5:0] FN_OR  = 6'b011110;
  localparam logic [5:0] FN_XOR = 6'b010110;
  localparam logic [5:0] FN_NOR = 6'b010001;
  localparam logic [5:0] FN_A   = 6'b011010;
  localparam logic [5:0] FN_SLL = 6'b100000;
  localparam logic [5:0] FN_SRL = 6'b100001;
  localparam logic [5:0] FN_SRA = 6'b100011;
  localparam logic [5:0] FN_EQ  = 6'b110011;
  localparam logic [5:0] FN_NEQ = 6'b110001;
  localparam logic [5:0] FN_LT  = 6'b110101;
  localparam logic [5:0] FN_LEZ = 6'b111101;
  localparam logic [5:0] FN_GEZ = 6'b111001;
  localparam logic [5:0] FN_GTZ = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed ALU test vector table: one row per function code.
// Expected results are precomputed constants.
module alu_bist_rom
  import alu_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [5:0]  fun,
  output logic        sign,
  output logic [31:0] expected
);

  localparam logic [31:0] OA = 32'hDAFB0219;
  localparam logic [31:0] OB = 32'h22B042D1;

  always_comb begin
    a        = 32'h0;
    b        = 32'h0;
    fun      = FN_ADD;
    sign     = 1'b0;
    expected = 32'h0;
    unique case (idx)
      4'd0: begin
        a = OA; b = OB; fun = FN_ADD;
        expected = 32'hFDAB44EA;
      end
      4'd1: begin
        a = OA; b = OB; fun = FN_SUB;
        expected = 32'hB84ABF48;
      end
      4'd2: begin
        a = OA; b = OB; fun = FN_AND;
        expected = 32'h02B00211;
      end
      4'd3: begin
        a = OA; b = OB; fun = FN_OR;
        expected = 32'hFAFB42D9;
      end
      4'd4: begin
        a = OA; b = OB; fun = FN_XOR;
        expected = 32'hF84B40C8;
      end
      4'd5: begin
        a = OA; b = OB; fun = FN_NOR;
        expected = 32'h0504BD26;
      end
      4'd6: begin
        a = OA; b = OB; fun = FN_A;
        expected = OA;
      end
      4'd7: begin
        a = 32'h4; b = 32'h12345678;
        fun = FN_SLL;
        expected = 32'h23456780;
      end
      4'd8: begin
        a = 32'h8; b = 32'hF0F0F0F0;
        fun = FN_SRL;
        expected = 32'h00F0F0F0;
      end
      4'd9: begin
        a = 32'h4; b = 32'h80000010;
        fun = FN_SRA;
        expected = 32'hF8000001;
      end
      4'd10: begin
        a = 32'h5A5A5A5A; b = 32'h5A5A5A5A;
        fun = FN_EQ;
        expected = 32'h1;
      end
      4'd11: begin
        a = 32'h1; b = 32'h1;
        fun = FN_NEQ;
        expected = 32'h0;
      end
      4'd12: begin
        a = 32'hFFFFFFFF; b = 32'h1;
        fun = FN_LT; sign = 1'b1;
        expected = 32'h1;
      end
      4'd13: begin
        a = 32'h0;
        fun = FN_LEZ;
        expected = 32'h1;
      end
      4'd14: begin
        a = 32'h80000000;
        fun = FN_GEZ;
        expected = 32'h0;
      end
      4'd15: begin
        a = 32'h5;
        fun = FN_GTZ;
        expected = 32'h1;
      end
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: drives table vectors onto the ALU,
// samples the result, counts mismatches and reports pass/fail.
module alu_bist
  import alu_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int SETTLE  = 1,
  parameter int ERR_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_fun,
  output logic             alu_sign,
  input  logic [31:0]      alu_s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail
);

  localparam int WW =
    (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [3:0] LAST =
    4'(NUM_VEC - 1);

  state_t        state, nstate;
  logic [3:0]    idx;
  logic [WW-1:0] wcnt;
  logic          clr;
  logic          miss;

  logic [31:0] r_a, r_b, r_exp;
  logic [5:0]  r_fun;
  logic        r_sign;

  alu_bist_rom u_rom (
    .idx      (idx),
    .a        (r_a),
    .b        (r_b),
    .fun      (r_fun),
    .sign     (r_sign),
    .expected (r_exp)
  );

  assign miss = (alu_s != r_exp);
  assign busy = (state == S_DRIVE) ||
                (state == S_WAIT)  ||
                (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= nstate;

  always_comb begin
    nstate = state;
    clr    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE:
        if (start) begin
          nstate = S_DRIVE;
          clr    = 1'b1;
        end
      S_DRIVE: nstate = S_WAIT;
      S_WAIT:
        if (wcnt == '0) nstate = S_CHECK;
      S_CHECK:
        nstate = (idx == LAST) ? S_DONE
                               : S_DRIVE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      wcnt       <= '0;
      err_count  <= '0;
      first_fail <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= '0;
      alu_sign   <= 1'b0;
    end else begin
      if (clr) begin
        idx        <= '0;
        err_count  <= '0;
        first_fail <= '0;
      end
      if (state == S_DRIVE) begin
        alu_a    <= r_a;
        alu_b    <= r_b;
        alu_fun  <= r_fun;
        alu_sign <= r_sign;
        wcnt     <= WW'(SETTLE - 1);
      end
      if (state == S_WAIT && wcnt != '0)
        wcnt <= wcnt - 1'b1;
      if (state == S_CHECK) begin
        if (miss) begin
          // first mismatch is the one seen while the count is still zero
          if (err_count == '0)
            first_fail <= idx;
          if (err_count != {ERR_W{1'b1}})
            err_count <= err_count + 1'b1;
        end
        if (idx != LAST)
          idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: behavioural ALU model with
// fault injection, directed and randomized runs.
module tb_alu_bist;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, start2;
  logic [31:0] alu_a, alu_b, alu_s;
  logic [5:0]  alu_fun;
  logic        alu_sign, busy, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;

  logic [31:0] alu_a2, alu_b2, alu_s2;
  logic [5:0]  alu_fun2;
  logic        alu_sign2, busy2, done2, pass2;
  logic [2:0]  err2;
  logic [3:0]  ff2;

  int total = 0;
  int bad   = 0;

  logic [15:0] flip;
  bit          zero, zero2;

  logic [31:0] ta [16];
  logic [31:0] tbv[16];
  logic [5:0]  tf [16];
  logic        ts [16];
  logic [31:0] eres[16];
  logic [31:0] sconst[4];

  always #5 clk = ~clk;

  alu_bist u_dut (
    .clk(clk), .reset(reset), .start(start),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_s(alu_s), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
    .first_fail(first_fail)
  );

  alu_bist #(.SETTLE(3), .ERR_W(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start2),
    .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_fun(alu_fun2), .alu_sign(alu_sign2),
    .alu_s(alu_s2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2),
    .first_fail(ff2)
  );

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b,
    input logic [5:0] f, input logic sg);
    logic [4:0] sh;
    sh = a[4:0];
    case (f)
      FN_ADD: return a + b;
      FN_SUB: return a - b;
      FN_AND: return a & b;
      FN_OR:  return a | b;
      FN_XOR: return a ^ b;
      FN_NOR: return ~(a | b);
      FN_A:   return a;
      FN_SLL: return b << sh;
      FN_SRL: return b >> sh;
      FN_SRA: return 32'($signed(b) >>> sh);
      FN_EQ:  return {31'b0, a == b};
      FN_NEQ: return {31'b0, a != b};
      FN_LT:
        return sg ? {31'b0, $signed(a) < $signed(b)}
                  : {31'b0, a < b};
      FN_LEZ: return {31'b0, $signed(a) <= 0};
      FN_GEZ: return {31'b0, $signed(a) >= 0};
      FN_GTZ: return {31'b0, $signed(a) > 0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int row_of(input logic [5:0] f);
    for (int i = 0; i < 16; i++)
      if (tf[i] == f) return i;
    return 0;
  endfunction

  always_comb begin
    alu_s = ref_alu(alu_a, alu_b, alu_fun, alu_sign);
    if (flip[row_of(alu_fun)]) alu_s = alu_s ^ 32'h1;
    if (zero) alu_s = 32'h0;
  end

  always_comb begin
    alu_s2 = ref_alu(alu_a2, alu_b2, alu_fun2, alu_sign2);
    if (zero2) alu_s2 = 32'h0;
  end

  task automatic chk(input string tag,
    input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic run1(input bit chk_vec,
    input bit poke, input bit abort);
    int t, nb, k, e_err, e_ff;
    bit got;
    e_err = 0; e_ff = 0; got = 0;
    for (int r = 0; r < 16; r++)
      if (zero ? (eres[r] != 0) : flip[r]) begin
        if (!got) e_ff = r;
        got = 1;
        e_err++;
      end
    if (e_err > 31) e_err = 31;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0; nb = 0;
    while (t < 400) begin
      if (abort && t == 23) begin
        reset = 1'b1; #1;
        chk("abort_async_busy", 32'(busy), 0);
        chk("abort_async_err", 32'(err_count), 0);
        chk("abort_async_a", alu_a, 0);
        @(posedge clk); #1;
        chk("abort_edge_busy", 32'(busy), 0);
        chk("abort_edge_done", 32'(done), 0);
        chk("abort_edge_fun", 32'(alu_fun), 0);
        chk("abort_edge_ff", 32'(first_fail), 0);
        @(negedge clk) reset = 1'b0;
        return;
      end
      if (chk_vec && t >= 1 && t <= 46 &&
          (t - 1) % 3 == 0) begin
        k = (t - 1) / 3;
        chk($sformatf("vec%0d_a", k), alu_a, ta[k]);
        chk($sformatf("vec%0d_b", k), alu_b, tbv[k]);
        chk($sformatf("vec%0d_fun", k),
            32'(alu_fun), 32'(tf[k]));
        chk($sformatf("vec%0d_sign", k),
            32'(alu_sign), 32'(ts[k]));
        if (k < 4)
          chk($sformatf("vec%0d_s", k), alu_s, sconst[k]);
      end
      if (busy) nb++;
      if (done) break;
      start = poke && (t == 10 || t == 30);
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk("busy_cycles", 32'(nb), 48);
    chk("done", 32'(done), 1);
    chk("pass", 32'(pass), 32'(e_err == 0));
    chk("err_count", 32'(err_count), 32'(e_err));
    chk("first_fail", 32'(first_fail), 32'(e_ff));
  endtask

  task automatic run2();
    int t, nb, e_err;
    e_err = 0;
    if (zero2)
      for (int r = 0; r < 16; r++)
        if (eres[r] != 0) e_err++;
    if (e_err > 7) e_err = 7;
    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    t = 0; nb = 0;
    while (t < 400) begin
      if (t == 5)
        chk("s3_vec0_fun", 32'(alu_fun2), 32'(FN_ADD));
      if (t == 6)
        chk("s3_vec1_fun", 32'(alu_fun2), 32'(FN_SUB));
      if (busy2) nb++;
      if (done2) break;
      @(posedge clk); #1;
      t++;
    end
    chk("s3_busy_cycles", 32'(nb), 80);
    chk("s3_done", 32'(done2), 1);
    chk("s3_pass", 32'(pass2), 32'(e_err == 0));
    chk("s3_err", 32'(err2), 32'(e_err));
  endtask

  initial begin
    ta  = '{default: 32'h0};
    tbv = '{default: 32'h0};
    ts  = '{default: 1'b0};
    tf  = '{FN_ADD, FN_SUB, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_A, FN_SLL,
            FN_SRL, FN_SRA, FN_EQ, FN_NEQ,
            FN_LT, FN_LEZ, FN_GEZ, FN_GTZ};
    for (int i = 0; i < 7; i++) begin
      ta[i]  = 32'hDAFB0219;
      tbv[i] = 32'h22B042D1;
    end
    ta[7] = 32'h4;  tbv[7] = 32'h12345678;
    ta[8] = 32'h8;  tbv[8] = 32'hF0F0F0F0;
    ta[9] = 32'h4;  tbv[9] = 32'h80000010;
    ta[10] = 32'h5A5A5A5A; tbv[10] = 32'h5A5A5A5A;
    ta[11] = 32'h1; tbv[11] = 32'h1;
    ta[12] = 32'hFFFFFFFF; tbv[12] = 32'h1;
    ts[12] = 1'b1;
    ta[13] = 32'h0;
    ta[14] = 32'h80000000;
    ta[15] = 32'h5;
    for (int i = 0; i < 16; i++)
      eres[i] = ref_alu(ta[i], tbv[i], tf[i], ts[i]);
    sconst = '{32'hFDAB44EA, 32'hB84ABF48,
               32'h02B00211, 32'hFAFB42D9};

    flip = 16'h0; zero = 0; zero2 = 0;
    start = 1'b0; start2 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_ff", 32'(first_fail), 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_fun", 32'(alu_fun), 0);
    @(negedge clk) reset = 1'b0;

    run1(1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", 32'(done), 1);

    flip = 16'h0022;
    run1(0, 0, 0);

    for (int n = 0; n < 3; n++) begin
      flip = 16'($urandom_range(0, 65535));
      run1(0, 0, 0);
    end

    flip = 16'h0; zero = 1;
    run1(0, 0, 0);
    zero = 0;

    flip = 16'h0006;
    run1(0, 0, 1);
    flip = 16'h0;
    run1(0, 0, 0);

    run1(0, 1, 0);

    run2();
    zero2 = 1;
    run2();
    zero2 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
